// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse meter: FSM state encoding,
// default parameter values and the counter saturation helper.
package pulse_pkg;

    // Measurement FSM states with a fixed 2-bit encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StHigh  = 2'd2,
        StLow   = 2'd3
    } state_e;

    localparam int unsigned DefaultWidth      = 8;
    localparam int unsigned DefaultSyncStages = 2;

    // Largest value a counter of the given bit width can hold.
    function automatic int unsigned max_count(input int unsigned width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchronizes the asynchronous pulse input and derives rise/fall strobes
// from the synchronized level.
module sync_edge
    import pulse_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
    input  logic clock,
    input  logic reset,
    input  logic signal,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    // One bit per flop between the pin and s_prev; all ones once both s and
    // s_prev hold real samples rather than reset-cleared zeros.
    logic [SYNC_STAGES:0]   fill_q;
    logic                   primed;

    // Synchronizer chain, one-cycle delayed copy of s and fill tracker.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
            fill_q   <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], signal};
            s_prev_q <= sync_q[SYNC_STAGES-1];
            fill_q   <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edge detection. Edges are suppressed until the chain has refilled after
    // reset, so a level already high at reset release never looks like a rise.
    always_comb begin
        primed = fill_q[SYNC_STAGES];
        s      = sync_q[SYNC_STAGES-1];
        rise   = primed & s & ~s_prev_q;
        fall   = primed & ~s & s_prev_q;
    end

endmodule

// File: rtl/pulse_meter.sv
// Measures high width and rise-to-rise period of an asynchronous pulse train
// in clock cycles, reporting each completed pulse with a one-cycle strobe.
module pulse_meter
    import pulse_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal,
    output logic [WIDTH-1:0] width_out,
    output logic [WIDTH-1:0] period_out,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(max_count(WIDTH));
    localparam logic [WIDTH-1:0] OneCnt = WIDTH'(1);

    logic             s;
    logic             rise;
    logic             fall;

    state_e           state_q;
    logic [WIDTH-1:0] hi_cnt_q;
    logic [WIDTH-1:0] per_cnt_q;
    logic             ovf_q;
    logic [WIDTH-1:0] width_q;
    logic [WIDTH-1:0] period_q;
    logic             overflow_q;
    logic             valid_q;

    logic             hi_sat;
    logic             per_sat;
    logic [WIDTH-1:0] hi_inc;
    logic [WIDTH-1:0] per_inc;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clock (clock),
        .reset (reset),
        .signal(signal),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    // Saturating increments; an attempt at the ceiling is recorded in ovf_q.
    always_comb begin
        hi_sat  = (hi_cnt_q == MaxCnt);
        per_sat = (per_cnt_q == MaxCnt);
        hi_inc  = hi_sat ? hi_cnt_q : hi_cnt_q + OneCnt;
        per_inc = per_sat ? per_cnt_q : per_cnt_q + OneCnt;
    end

    // Measurement FSM, counters and registered report outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            hi_cnt_q   <= '0;
            per_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            width_q    <= '0;
            period_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!s) begin
                        state_q <= StArmed;
                    end
                end
                StArmed: begin
                    if (rise) begin
                        hi_cnt_q  <= OneCnt;
                        per_cnt_q <= OneCnt;
                        ovf_q     <= 1'b0;
                        state_q   <= StHigh;
                    end
                end
                StHigh: begin
                    if (fall) begin
                        per_cnt_q <= per_inc;
                        ovf_q     <= ovf_q | per_sat;
                        state_q   <= StLow;
                    end else if (s) begin
                        hi_cnt_q  <= hi_inc;
                        per_cnt_q <= per_inc;
                        ovf_q     <= ovf_q | hi_sat | per_sat;
                    end
                end
                StLow: begin
                    if (rise) begin
                        // Report and restart in the same cycle: no dead cycle
                        // between back-to-back pulses.
                        width_q    <= hi_cnt_q;
                        period_q   <= per_cnt_q;
                        overflow_q <= ovf_q;
                        valid_q    <= 1'b1;
                        hi_cnt_q   <= OneCnt;
                        per_cnt_q  <= OneCnt;
                        ovf_q      <= 1'b0;
                        state_q    <= StHigh;
                    end else if (!s) begin
                        per_cnt_q <= per_inc;
                        ovf_q     <= ovf_q | per_sat;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign width_out  = width_q;
    assign period_out = period_q;
    assign overflow   = overflow_q;
    assign valid      = valid_q;
    assign busy       = (state_q == StHigh) || (state_q == StLow);

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Receive-side companion to the pulse generator: takes an asynchronous single-bit pulse train and measures it.
- Measures high width and rise-to-rise period in clock cycles.
- Reports each completed measurement with a one-cycle valid strobe.
- Used in benches and on-chip to check generated pulse trains against expected timing.

Parameters:
- WIDTH, 8: bit width of the width/period counters and outputs.
- SYNC_STAGES, 2: number of synchronizer flops on `signal`; legal range is 2 or more.

Ports:
- clock  input  1  system clock; all logic runs on the rising edge.
- reset  input  1  synchronous, active-high reset.
- signal  input  1  asynchronous pulse input being measured.
- width_out  output  WIDTH  high time of the last complete pulse, in cycles.
- period_out  output  WIDTH  rise-to-rise time of the last complete pulse, in cycles.
- valid  output  1  one-cycle strobe; width_out, period_out and overflow are new in this cycle.
- overflow  output  1  a counter saturated during the reported measurement.
- busy  output  1  high while a measurement is in progress (states HIGH or LOW).

Behaviour:
- Reset:
  - Synchronous, active-high, on the single clock.
  - While reset is sampled high: FSM goes to IDLE; width_out=0, period_out=0, valid=0, overflow=0, busy=0; all counters and synchronizer flops clear to 0.
  - Reset mid-measurement discards the partial measurement; no valid is produced for it.
- Input path:
  - `signal` passes through SYNC_STAGES flops to give s.
  - s_prev is s delayed one cycle.
  - rise = s & ~s_prev; fall = ~s & s_prev.
- FSM states (state register resets to IDLE):
  - IDLE: wait for s==0, then go to ARMED. This guarantees a pulse already high at reset release is never measured.
  - ARMED: on rise, load hi_cnt=1, per_cnt=1, ovf=0, then go to HIGH.
  - HIGH: while s==1, increment hi_cnt and per_cnt. On fall, increment per_cnt, hold hi_cnt, then go to LOW.
  - LOW: while s==0, increment per_cnt. On rise:
    - register width_out=hi_cnt, period_out=per_cnt, overflow=ovf;
    - assert valid for exactly 1 cycle;
    - reload hi_cnt=1, per_cnt=1, ovf=0;
    - go to HIGH. Back-to-back pulses are measured with no dead cycle.
- Counting rules:
  - width = number of cycles s is high; period = number of cycles from one rise to the next.
  - Both counters saturate at 2^WIDTH-1; on any increment attempt at saturation, set ovf=1.
  - After saturation the measurement still completes at the next rise and reports the saturated values with overflow=1.
- Latency: valid rises SYNC_STAGES+1 clock edges after the first clock edge that samples `signal` high at the start of the next pulse.
- Output holding: width_out, period_out and overflow hold their values between strobes; valid is 0 except on the strobe cycle.
- Minimum pulse: a 1-cycle high pulse (as sampled) gives width_out=1. A 1-cycle low gap gives period_out=width+1.
- Constant input: if `signal` is held constant forever, valid is never asserted; busy stays high in HIGH or LOW.
- Combinational outputs: busy = (state==HIGH) or (state==LOW). All other outputs are registered.

Decomposition:
- Package pulse_pkg:
  - state enum {IDLE, ARMED, HIGH, LOW} and its 2-bit encoding;
  - default WIDTH and SYNC_STAGES constants;
  - saturation constant function max_count(WIDTH).
- Sub-module sync_edge (parameter SYNC_STAGES):
  - inputs clock, reset, signal;
  - outputs s, rise, fall.
- pulse_meter holds the FSM, the counters and the output registers.

Test Plan:
- Periodic train, high 3 / low 5 cycles, repeated 4 times → three valid strobes, each width_out=3, period_out=8, overflow=0, strobes 8 cycles apart.
- `signal` high while reset is asserted, reset released, `signal` stays high 6 cycles, falls, then a 2-high/4-low train → no valid for the first pulse; first report is width_out=2, period_out=6.
- Single-cycle pulses (high 1 / low 1) → width_out=1, period_out=2, with valid every 2 cycles after the first.
- WIDTH=4, `signal` high 20 cycles then low 3, then rise → width_out=15, period_out=15, overflow=1; the next normal pulse reports overflow=0.
- Reset pulsed for 1 cycle in the middle of a HIGH phase → valid=0 and busy=0 the cycle after reset; no report for the interrupted pulse; measurement resumes only after s is seen low then rising.
- `signal` held low 100 cycles after reset → valid never asserted; busy=0 (ARMED), all outputs 0.
